// File: rtl/mask_ser_pkg.sv
// Shared types and helpers for the mask stream serializer.
//   res_e   : per-row resolution code; RES_RSVD rows are dropped.
//   state_e : output FSM states.
//   step_of : maps a resolution code to its beats-per-row count.
package mask_ser_pkg;

  localparam int unsigned BEAT_W = 8;

  typedef enum logic [1:0] {
    RES_0    = 2'b00,
    RES_1    = 2'b01,
    RES_2    = 2'b10,
    RES_RSVD = 2'b11
  } res_e;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // The step values are module parameters, so the caller passes them in.
  function automatic logic [BEAT_W-1:0] step_of(input res_e            res,
                                                input logic [BEAT_W-1:0] step0,
                                                input logic [BEAT_W-1:0] step1,
                                                input logic [BEAT_W-1:0] step2);
    logic [BEAT_W-1:0] step;
    case (res)
      RES_0:   step = step0;
      RES_1:   step = step1;
      RES_2:   step = step2;
      default: step = '0;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/mask_row_buf2.sv
// Two-entry row buffer for the mask stream serializer.
// Holds an ACTIVE row (data + resolved step) and a PENDING row (data + resolution code).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wr_en        : store wr_data/wr_res this cycle (caller filters reserved rows)
//   wr_data      : row to store
//   wr_res       : resolution of the row being stored
//   vacate       : ACTIVE row finished its last beat this cycle
//   in_ready     : registered !pend_v, low during reset
//   act_data     : ACTIVE row contents
//   act_step     : beats per ACTIVE row
//   act_v        : ACTIVE row valid
//   pend_v       : PENDING row valid
module mask_row_buf2
  import mask_ser_pkg::*;
#(
  parameter int unsigned IP_W  = 640,
  parameter int unsigned STEP0 = 16,
  parameter int unsigned STEP1 = 32,
  parameter int unsigned STEP2 = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IP_W-1:0]   wr_data,
  input  res_e              wr_res,
  input  logic              vacate,
  output logic              in_ready,
  output logic [IP_W-1:0]   act_data,
  output logic [BEAT_W-1:0] act_step,
  output logic              act_v,
  output logic              pend_v
);

  localparam logic [BEAT_W-1:0] S0 = BEAT_W'(STEP0);
  localparam logic [BEAT_W-1:0] S1 = BEAT_W'(STEP1);
  localparam logic [BEAT_W-1:0] S2 = BEAT_W'(STEP2);

  logic [IP_W-1:0]   act_data_q, act_data_d;
  logic [BEAT_W-1:0] act_step_q, act_step_d;
  logic              act_v_q, act_v_d;
  logic [IP_W-1:0]   pend_data_q, pend_data_d;
  res_e              pend_res_q, pend_res_d;
  logic              pend_v_q, pend_v_d;
  logic              in_ready_q;

  always_comb begin
    act_data_d  = act_data_q;
    act_step_d  = act_step_q;
    act_v_d     = act_v_q;
    pend_data_d = pend_data_q;
    pend_res_d  = pend_res_q;
    pend_v_d    = pend_v_q;

    // Promote PENDING into a finishing ACTIVE slot.
    if (vacate) begin
      act_v_d  = pend_v_q;
      pend_v_d = 1'b0;
      if (pend_v_q) begin
        act_data_d = pend_data_q;
        act_step_d = step_of(pend_res_q, S0, S1, S2);
      end
    end

    // A new row takes ACTIVE only when ACTIVE ends up free without a promote;
    // otherwise it queues behind in PENDING (which may be vacated on the same edge).
    if (wr_en) begin
      if (!act_v_q || (vacate && !pend_v_q)) begin
        act_data_d = wr_data;
        act_step_d = step_of(wr_res, S0, S1, S2);
        act_v_d    = 1'b1;
      end else begin
        pend_data_d = wr_data;
        pend_res_d  = wr_res;
        pend_v_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_step_q <= '0;
      act_v_q    <= 1'b0;
      pend_res_q <= RES_0;
      pend_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      act_step_q <= act_step_d;
      act_v_q    <= act_v_d;
      pend_res_q <= pend_res_d;
      pend_v_q   <= pend_v_d;
      in_ready_q <= !pend_v_d;
    end
  end

  // Row payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    act_data_q  <= act_data_d;
    pend_data_q <= pend_data_d;
  end

  assign in_ready = in_ready_q;
  assign act_data = act_data_q;
  assign act_step = act_step_q;
  assign act_v    = act_v_q;
  assign pend_v   = pend_v_q;

endmodule

// File: rtl/mask_stream_serializer.sv
// Mask stream serializer: accepts IP_W-bit mask rows and emits OP_W-bit beats where
// lane i at beat k carries row bit [i*STEP + k]; bits at or beyond IP_W read as 0.
// Optional feature macro: MASK_SER_BEAT_IDX_EN adds output beat_idx (current k) and a
// check that k stays below the row's STEP.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   din, din_res               : row and its resolution code
//   din_valid / din_ready      : row handshake
//   dout, dout_last            : current beat, final-beat flag
//   dout_valid / dout_ready    : beat handshake
//   busy                       : a row is active or pending
//   res_err                    : one-cycle pulse after a reserved-resolution row is dropped
//   beat_idx (optional)        : current beat index
module mask_stream_serializer
  import mask_ser_pkg::*;
#(
  parameter int unsigned IP_W  = 640,
  parameter int unsigned OP_W  = 20,
  parameter int unsigned STEP0 = 16,
  parameter int unsigned STEP1 = 32,
  parameter int unsigned STEP2 = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IP_W-1:0]   din,
  input  logic [1:0]        din_res,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [OP_W-1:0]   dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              res_err
`ifdef MASK_SER_BEAT_IDX_EN
  ,
  output logic [BEAT_W-1:0] beat_idx
`endif
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              res_err_q;

  logic              xfer;
  logic              rsvd;
  logic              row_wr;
  logic              beat_acc;
  logic              vacate;

  logic [IP_W-1:0]   act_data;
  logic [BEAT_W-1:0] act_step;
  logic              act_v;
  logic              pend_v;
  logic [OP_W-1:0]   lane_bits;

  assign xfer     = din_valid && din_ready;
  assign rsvd     = (res_e'(din_res) == RES_RSVD);
  assign row_wr   = xfer && !rsvd;
  assign beat_acc = dout_valid && dout_ready;
  assign vacate   = beat_acc && dout_last;

  mask_row_buf2 #(
    .IP_W  (IP_W),
    .STEP0 (STEP0),
    .STEP1 (STEP1),
    .STEP2 (STEP2)
  ) u_row_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (row_wr),
    .wr_data  (din),
    .wr_res   (res_e'(din_res)),
    .vacate   (vacate),
    .in_ready (din_ready),
    .act_data (act_data),
    .act_step (act_step),
    .act_v    (act_v),
    .pend_v   (pend_v)
  );

  // FSM: STREAM tracks "ACTIVE holds a row" one cycle after it fills.
  always_comb begin
    state_d    = state_q;
    dout_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (row_wr) state_d = STREAM;
      end
      STREAM: begin
        dout_valid = 1'b1;
        // A row written while ACTIVE drains with PENDING empty refills ACTIVE directly.
        if (vacate && !pend_v && !row_wr) state_d = IDLE;
      end
    endcase
  end

  assign dout_last = dout_valid && (beat_q == act_step - 8'd1);

  always_comb begin
    beat_d = beat_q;
    if (beat_acc) beat_d = dout_last ? '0 : beat_q + 8'd1;
  end

  // Lane mux: shifting past the top of the row naturally yields 0.
  for (genvar g = 0; g < OP_W; g++) begin : g_lane
    logic [31:0] amt;
    assign amt          = 32'(g) * 32'(act_step) + 32'(beat_q);
    assign lane_bits[g] = 1'(act_data >> amt);
  end

  assign dout    = dout_valid ? lane_bits : '0;
  assign busy    = act_v | pend_v;
  assign res_err = res_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      res_err_q <= xfer && rsvd;
    end
  end

`ifdef MASK_SER_BEAT_IDX_EN
  assign beat_idx = dout_valid ? beat_q : '0;

  a_beat_in_range : assert property (@(posedge clk) disable iff (rst)
    dout_valid |-> (beat_q < act_step));
`endif

endmodule
